// File: rtl/sdio_tx_byte_feeder_if.sv
// rtl/sdio_tx_byte_feeder_if.sv - application, command and serializer signals of the tx byte feeder
// master drives writes, transaction starts and byte requests; slave is the feeder itself.
interface sdio_tx_byte_feeder_if #(
  parameter int DEPTH_LOG2 = 9
);
  logic [7:0]          wr_byte;
  logic                wr_strobe;
  logic                flush;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                fifo_full;
  logic                tx_start;
  logic [8:0]          tx_count;
  logic                start_write;
  logic                data_req;
  logic [7:0]          data;
  logic                data_strobe;
  logic                data_empty;
  logic                busy;
  logic                underrun;
  logic                overflow;

  modport master (
    output wr_byte, wr_strobe, flush, tx_start, tx_count, data_req,
    input  fifo_level, fifo_full, start_write, data, data_strobe, data_empty,
           busy, underrun, overflow
  );

  modport slave (
    input  wr_byte, wr_strobe, flush, tx_start, tx_count, data_req,
    output fifo_level, fifo_full, start_write, data, data_strobe, data_empty,
           busy, underrun, overflow
  );
endinterface

// File: rtl/sdio_tx_byte_feeder.sv
// rtl/sdio_tx_byte_feeder.sv - FIFO-backed byte source for the SDIO DAT transmitter
// Serves exactly the commanded byte count per transaction, padding on underrun.
module sdio_tx_byte_feeder #(
  parameter int         DEPTH_LOG2 = 9,
  parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
  input logic                 clock,
  input logic                 reset,
  sdio_tx_byte_feeder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [9:0]            remaining;
  logic [7:0]            data_q;
  logic                  start_write_q;
  logic                  data_strobe_q;
  logic                  data_empty_q;
  logic                  busy_q;
  logic                  underrun_q;
  logic                  overflow_q;
  logic                  serve;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // A pop frees a slot, so a push into a full FIFO still lands that cycle.
  always_comb begin
    serve = (state == ACTIVE) && bus.data_req && (remaining != 10'd0);
    pop   = serve && (level != '0) && !bus.flush;
    push  = bus.wr_strobe && !bus.flush && ((level != FULL_LEVEL) || pop);
    drop  = bus.wr_strobe && !bus.flush && (level == FULL_LEVEL) && !pop;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_byte;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      remaining     <= 10'd0;
      data_q        <= 8'h00;
      start_write_q <= 1'b0;
      data_strobe_q <= 1'b0;
      data_empty_q  <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      start_write_q <= 1'b0;
      data_strobe_q <= 1'b0;

      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      end

      case (state)
        IDLE, DONE: begin
          if (bus.tx_start) begin
            remaining     <= (bus.tx_count == 9'd0) ? 10'd512 : {1'b0, bus.tx_count};
            start_write_q <= 1'b1;
            data_empty_q  <= 1'b0;
            underrun_q    <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b1;
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.data_req) begin
            if (remaining != 10'd0) begin
              data_strobe_q <= 1'b1;
              remaining     <= remaining - 10'd1;
              if (pop) begin
                data_q <= mem[rd_ptr];
              end else begin
                data_q     <= PAD_BYTE;
                underrun_q <= 1'b1;
              end
            end else begin
              data_empty_q <= 1'b1;
              busy_q       <= 1'b0;
              state        <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the start branch so a drop in the start cycle is still recorded.
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.fifo_level  = level;
  assign bus.fifo_full   = (level == FULL_LEVEL);
  assign bus.start_write = start_write_q;
  assign bus.data        = data_q;
  assign bus.data_strobe = data_strobe_q;
  assign bus.data_empty  = data_empty_q;
  assign bus.busy        = busy_q;
  assign bus.underrun    = underrun_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_sdio_tx_byte_feeder.sv
// tb/tb_sdio_tx_byte_feeder.sv - directed and randomized checks against a queue-based reference model
module tb_sdio_tx_byte_feeder;
  localparam int         DL    = 9;
  localparam int         DEPTH = 1 << DL;
  localparam logic [7:0] PAD   = 8'hFF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sdio_tx_byte_feeder_if #(.DEPTH_LOG2(DL)) bus ();

  sdio_tx_byte_feeder #(.DEPTH_LOG2(DL), .PAD_BYTE(PAD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  byte unsigned q[$];
  bit           m_active;
  int           m_rem;
  bit           m_sw, m_stb, m_empty, m_busy, m_under, m_over;
  logic [7:0]   m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level view: a byte queue, a bytes-left counter and sticky flags.
  task automatic model_step();
    int n = q.size();
    bit popped = 1'b0;
    if (reset) begin
      q.delete();
      m_active = 0; m_rem = 0; m_sw = 0; m_stb = 0; m_empty = 0;
      m_busy = 0; m_under = 0; m_over = 0; m_data = 8'h00;
      return;
    end
    m_sw  = 0;
    m_stb = 0;
    if (!m_active && bus.tx_start) begin
      m_rem    = (bus.tx_count == 9'd0) ? 512 : int'(bus.tx_count);
      m_sw     = 1; m_empty = 0; m_under = 0; m_over = 0; m_busy = 1;
      m_active = 1;
    end else if (m_active && bus.data_req) begin
      if (m_rem > 0) begin
        m_stb = 1;
        m_rem--;
        if (n > 0 && !bus.flush) begin
          m_data = q.pop_front();
          popped = 1'b1;
        end else begin
          m_data  = PAD;
          m_under = 1;
        end
      end else begin
        m_empty  = 1;
        m_busy   = 0;
        m_active = 0;
      end
    end
    if (bus.flush) q.delete();
    else if (bus.wr_strobe) begin
      if (n < DEPTH || popped) q.push_back(bus.wr_byte);
      else m_over = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("fifo_level",  bus.fifo_level,  q.size());
    check("fifo_full",   bus.fifo_full,   q.size() == DEPTH);
    check("start_write", bus.start_write, m_sw);
    check("data_strobe", bus.data_strobe, m_stb);
    check("data",        bus.data,        m_data);
    check("data_empty",  bus.data_empty,  m_empty);
    check("busy",        bus.busy,        m_busy);
    check("underrun",    bus.underrun,    m_under);
    check("overflow",    bus.overflow,    m_over);
    reset         = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.flush     = 1'b0;
    bus.tx_start  = 1'b0;
    bus.data_req  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_byte   = b;
    bus.wr_strobe = 1'b1;
    tick();
  endtask

  task automatic start(input int cnt);
    bus.tx_count = 9'(cnt);
    bus.tx_start = 1'b1;
    tick();
  endtask

  task automatic req(input int gap);
    bus.data_req = 1'b1;
    tick();
    repeat (gap - 1) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_byte = 8'h00; bus.wr_strobe = 1'b0; bus.flush = 1'b0;
    bus.tx_start = 1'b0; bus.tx_count = 9'd0; bus.data_req = 1'b0;
    tick();
    check("rst_level", bus.fifo_level, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_data",  bus.data, 8'h00);

    // Four bytes, four strobes, then end-of-data.
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    start(4);
    check("s1_start_write", bus.start_write, 1);
    req(1);
    check("s1_first_byte", bus.data, 8'h10);
    repeat (7) tick();
    for (int i = 0; i < 4; i++) req(8);
    check("s1_empty", bus.data_empty, 1);
    check("s1_busy",  bus.busy, 0);
    check("s1_level", bus.fifo_level, 0);

    // Underrun pads the third byte; next start clears the flag.
    push(8'hA0); push(8'hA1);
    start(3);
    for (int i = 0; i < 4; i++) req(3);
    check("s2_underrun", bus.underrun, 1);
    check("s2_empty",    bus.data_empty, 1);
    start(1);
    check("s2_underrun_clr", bus.underrun, 0);
    req(2); req(2);
    bus.flush = 1'b1; tick();

    // Full FIFO, overflow, full-block transfer with simultaneous push/pop.
    for (int i = 0; i < DEPTH; i++) push(8'(i ^ 8'h5A));
    check("s3_full", bus.fifo_full, 1);
    push(8'h55);
    check("s3_overflow", bus.overflow, 1);
    check("s3_level", bus.fifo_level, DEPTH);
    start(0);
    bus.wr_byte = 8'hC3; bus.wr_strobe = 1'b1; bus.data_req = 1'b1;
    tick();
    check("s4_level",    bus.fifo_level, DEPTH);
    check("s4_overflow", bus.overflow, 0);
    tick();
    for (int i = 1; i < DEPTH; i++) req(2);
    check("s3_last_byte", bus.data, 8'((DEPTH - 1) ^ 8'h5A));
    req(2);
    check("s3_empty", bus.data_empty, 1);
    start(1);
    req(2);
    check("s4_carried", bus.data, 8'hC3);
    req(2);

    // Reset aborts a transaction mid-flight.
    for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
    start(6);
    req(2); req(2);
    reset = 1'b1; tick();
    check("s5_busy",  bus.busy, 0);
    check("s5_level", bus.fifo_level, 0);
    bus.data_req = 1'b1; tick();
    check("s5_nostrobe", bus.data_strobe, 0);

    // Start while active is ignored.
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    start(3);
    req(2);
    start(7);
    check("s6_no_restart", bus.start_write, 0);
    req(2); req(2); req(2);
    check("s6_empty", bus.data_empty, 1);
    check("s6_level", bus.fifo_level, 2);

    for (int c = 0; c < 4000; c++) begin
      bus.wr_byte   = 8'($urandom);
      bus.wr_strobe = ($urandom_range(0, 99) < 40);
      bus.flush     = ($urandom_range(0, 99) < 2);
      bus.tx_start  = ($urandom_range(0, 99) < 5);
      bus.tx_count  = 9'($urandom_range(0, 24));
      bus.data_req  = ($urandom_range(0, 99) < 30);
      reset         = ($urandom_range(0, 999) < 5);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
